// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl: Z80 interrupt state (IFF1/IFF2, IM, I register) and
// instruction-boundary NMI/INT arbitration with a req/ack handshake toward
// the core sequencer. All outputs except pv_iff2 come straight from flops;
// pv_iff2 has to be combinational because LD A,I/R consumes it on the same
// boundary cycle.
module z80_irq_ctrl #(
  parameter bit         NMOS_PV_BUG = 1'b1,
  parameter logic [7:0] RESET_I     = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nmi_n,
  input  logic        int_n,
  input  logic        insn_done,
  input  logic        insn_ei,
  input  logic        insn_di,
  input  logic        insn_retn,
  input  logic        insn_im_we,
  input  logic [1:0]  insn_im,
  input  logic        insn_ld_air,
  input  logic        i_we,
  input  logic [7:0]  i_wdata,
  output logic        irq_req,
  output logic        irq_nmi,
  output logic [15:0] irq_vector,
  input  logic        irq_ack,
  output logic        iff1,
  output logic        iff2,
  output logic        pv_iff2,
  output logic [1:0]  im,
  output logic [7:0]  reg_i
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [15:0] NMI_VECTOR = 16'h0066;

  // Maskable-interrupt service address for the current mode. Mode 0 hands
  // out 0 because the sequencer fetches the opcode from the bus; mode 2
  // supplies the table page and the sequencer ORs in the bus byte.
  function automatic logic [15:0] int_vector(input logic [1:0] mode,
                                             input logic [7:0] ireg);
    logic [15:0] vec;
    case (mode)
      2'd0:    vec = 16'h0000;
      2'd1:    vec = 16'h0038;
      2'd2:    vec = {ireg, 8'h00};
      default: vec = 16'h0000;
    endcase
    return vec;
  endfunction

  state_t      state_r,      state_s;
  logic        iff1_r,       iff1_s;
  logic        iff2_r,       iff2_s;
  logic [1:0]  im_r,         im_s;
  logic [7:0]  reg_i_r,      reg_i_s;
  logic        irq_req_r,    irq_req_s;
  logic        irq_nmi_r,    irq_nmi_s;
  logic [15:0] irq_vector_r, irq_vector_s;
  logic        nmi_latch_r,  nmi_latch_s;
  logic        nmi_prev_r;
  logic        ei_shadow_r,  ei_shadow_s;

  logic        nmi_edge_s;
  logic        boundary_s;
  logic        nmi_pending_s;
  logic        int_accept_s;

  // Boundary qualification: NMI edge detect and the maskable acceptance
  // test (pre-update iff1; DI or EI at this boundary blocks acceptance).
  always_comb begin
    nmi_edge_s    = nmi_prev_r & ~nmi_n;
    boundary_s    = (state_r == ST_IDLE) & insn_done;
    nmi_pending_s = nmi_latch_r | nmi_edge_s;
    int_accept_s  = 1'b0;
    if (boundary_s && !nmi_pending_s && !int_n && iff1_r && !insn_di && !insn_ei) begin
      int_accept_s = 1'b1;
    end else begin
      int_accept_s = 1'b0;
    end
  end

  // P/V source for LD A,I/R, including the NMOS quirk that reads 0 when an
  // INT is taken on the very boundary of the LD.
  always_comb begin
    pv_iff2 = iff2_r;
    if (NMOS_PV_BUG && insn_ld_air && int_accept_s) begin
      pv_iff2 = 1'b0;
    end else begin
      pv_iff2 = iff2_r;
    end
  end

  // Next-state logic: EI/DI/RETN/IM updates, boundary decision, and the
  // request/acknowledge handshake. insn_done during REQ is ignored.
  always_comb begin
    state_s      = state_r;
    iff1_s       = iff1_r;
    iff2_s       = iff2_r;
    im_s         = im_r;
    reg_i_s      = reg_i_r;
    irq_req_s    = irq_req_r;
    irq_nmi_s    = irq_nmi_r;
    irq_vector_s = irq_vector_r;
    nmi_latch_s  = nmi_latch_r | nmi_edge_s;
    ei_shadow_s  = ei_shadow_r;

    if (i_we) begin
      reg_i_s = i_wdata;
    end else begin
      reg_i_s = reg_i_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (insn_done) begin
          if (insn_di) begin
            iff1_s      = 1'b0;
            iff2_s      = 1'b0;
            ei_shadow_s = 1'b0;
          end else if (insn_ei) begin
            iff1_s      = 1'b1;
            iff2_s      = 1'b1;
            ei_shadow_s = 1'b1;
          end else if (insn_retn) begin
            iff1_s      = iff2_r;
            ei_shadow_s = 1'b0;
          end else begin
            ei_shadow_s = 1'b0;
          end

          if (insn_im_we) begin
            im_s = (insn_im == 2'd3) ? 2'd0 : insn_im;
          end else begin
            im_s = im_r;
          end

          if (nmi_pending_s) begin
            state_s      = ST_REQ;
            irq_req_s    = 1'b1;
            irq_nmi_s    = 1'b1;
            irq_vector_s = NMI_VECTOR;
          end else if (int_accept_s) begin
            state_s      = ST_REQ;
            irq_req_s    = 1'b1;
            irq_nmi_s    = 1'b0;
            irq_vector_s = int_vector(im_s, reg_i_r);
          end else begin
            state_s   = ST_IDLE;
            irq_req_s = 1'b0;
          end
        end else begin
          state_s   = ST_IDLE;
          irq_req_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_s   = ST_IDLE;
          irq_req_s = 1'b0;
          if (irq_nmi_r) begin
            iff1_s      = 1'b0;
            nmi_latch_s = 1'b0;
          end else begin
            iff1_s = 1'b0;
            iff2_s = 1'b0;
          end
        end else begin
          state_s   = ST_REQ;
          irq_req_s = 1'b1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        irq_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any pending request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      iff1_r       <= 1'b0;
      iff2_r       <= 1'b0;
      im_r         <= 2'd0;
      reg_i_r      <= RESET_I;
      irq_req_r    <= 1'b0;
      irq_nmi_r    <= 1'b0;
      irq_vector_r <= 16'h0000;
      nmi_latch_r  <= 1'b0;
      nmi_prev_r   <= 1'b1;
      ei_shadow_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      iff1_r       <= iff1_s;
      iff2_r       <= iff2_s;
      im_r         <= im_s;
      reg_i_r      <= reg_i_s;
      irq_req_r    <= irq_req_s;
      irq_nmi_r    <= irq_nmi_s;
      irq_vector_r <= irq_vector_s;
      nmi_latch_r  <= nmi_latch_s;
      nmi_prev_r   <= nmi_n;
      ei_shadow_r  <= ei_shadow_s;
    end
  end

  assign irq_req    = irq_req_r;
  assign irq_nmi    = irq_nmi_r;
  assign irq_vector = irq_vector_r;
  assign iff1       = iff1_r;
  assign iff2       = iff2_r;
  assign im         = im_r;
  assign reg_i      = reg_i_r;

endmodule

// File: doc/z80_irq_ctrl.md
Name: z80_irq_ctrl

Overview:
- Owns the Z80 interrupt state: IFF1, IFF2, interrupt mode IM, and the I register.
- Decides at each instruction boundary whether the core sequencer takes an NMI or a maskable INT, and hands it the service vector through a req/ack handshake.
- Supplies the iff2 and reg_i values that LD A,I / LD A,R consume for A and the P/V flag.
- Sits beside the core sequencer; the sequencer reports instruction boundaries and decoded EI/DI/RETI/RETN/IM/LD I,A events.

Parameters:
- NMOS_PV_BUG, 1, when 1 the iff2 output presented to LD A,I/R is forced 0 if an INT is accepted at that same boundary.
- RESET_I, 8'h00, reset value of reg_i.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- nmi_n  in  1  NMI pin, falling-edge sensitive, pre-synchronised.
- int_n  in  1  INT pin, level sensitive, pre-synchronised.
- insn_done  in  1  one-cycle pulse on the last cycle of every instruction (the boundary).
- insn_ei  in  1  with insn_done: instruction was EI.
- insn_di  in  1  with insn_done: instruction was DI.
- insn_retn  in  1  with insn_done: instruction was RETN or RETI.
- insn_im_we  in  1  with insn_done: IM n executed.
- insn_im  in  2  mode for IM n (0, 1, 2).
- insn_ld_air  in  1  with insn_done: instruction was LD A,I or LD A,R.
- i_we  in  1  write reg_i (LD I,A); independent of insn_done.
- i_wdata  in  8  data for reg_i.
- irq_req  out  1  service request to the sequencer.
- irq_nmi  out  1  qualifies irq_req: 1 = NMI, 0 = INT.
- irq_vector  out  16  service address; valid while irq_req=1.
- irq_ack  in  1  sequencer accepts the request this cycle.
- iff1  out  1  interrupt enable flip-flop 1.
- iff2  out  1  interrupt enable flip-flop 2.
- pv_iff2  out  1  P/V value for LD A,I/R.
- im  out  2  current interrupt mode.
- reg_i  out  8  I register.

Behaviour:
- Reset (async, reset_n=0): iff1=0, iff2=0, im=0, reg_i=RESET_I, irq_req=0, irq_nmi=0, irq_vector=0, nmi latch=0, ei_shadow=0, state=IDLE.
- NMI edge: the previous nmi_n is registered. A 1->0 transition sets the nmi latch, which holds until the NMI is acked. A second edge while latched is absorbed.
- EI/DI:
  - On insn_done with insn_ei: iff1=iff2=1, ei_shadow=1.
  - On insn_done with insn_di: iff1=iff2=0, ei_shadow=0.
  - ei_shadow blocks INT acceptance at the boundary ending EI only. It clears at the next insn_done; consecutive EIs keep it set.
- RETN/RETI at insn_done: iff1 = iff2.
- IM: at insn_done with insn_im_we: im = insn_im. Value 3 is treated as 0.
- I register: i_we writes reg_i next cycle. pv_iff2 = iff2 combinationally, except when NMOS_PV_BUG=1, insn_ld_air=1, and an INT is accepted at that boundary; then pv_iff2=0.
- Boundary decision (state IDLE, insn_done=1), evaluated after that instruction's EI/DI/RETN updates:
  - NMI latched -> state REQ, irq_nmi=1, irq_vector=16'h0066. Priority over INT.
  - Else int_n=0, iff1=1 (pre-update value), and ei_shadow=0 -> state REQ, irq_nmi=0, irq_vector per im:
    - im 0: 16'h0000; sequencer fetches the opcode from the bus.
    - im 1: 16'h0038.
    - im 2: {reg_i, 8'h00}; sequencer ORs in the bus byte.
  - Else stay IDLE.
- REQ: irq_req=1 from the cycle after the boundary. Vector and irq_nmi are stable until ack.
  - On irq_ack=1:
    - NMI: iff1=0, iff2 unchanged, nmi latch cleared.
    - INT: iff1=iff2=0.
  - irq_req drops the next cycle; return to IDLE.
- insn_done asserted during REQ is a protocol error: ignored, no state change.
- DI arriving simultaneously with a pending INT decision: DI wins (pre-update iff1 used only when DI is absent).
- reset_n asserted mid-REQ aborts the request immediately.

Test Plan:
- Reset, then EI + insn_done, int_n=0, im=1 -> no irq_req at the EI boundary. At the next insn_done, irq_req=1, irq_nmi=0, irq_vector=16'h0038. On irq_ack, iff1=iff2=0.
- iff1=iff2=1, nmi_n falls, int_n=0 at the same boundary -> irq_nmi=1, irq_vector=16'h0066. After ack, iff1=0, iff2=1. RETN + insn_done -> iff1=1.
- i_we with i_wdata=8'hA5, IM 2, EI, then NOP boundary with int_n=0 -> irq_vector=16'hA500.
- NMOS_PV_BUG=1, iff2=1, insn_ld_air with int_n=0 accepted at that boundary -> pv_iff2=0. Repeat with int_n=1 -> pv_iff2=1.
- Two nmi_n falling edges before ack -> exactly one NMI request. int_n held 0 with iff1=0 -> no INT request.
- reset_n pulsed low while irq_req=1 -> irq_req=0 asynchronously, iff1=iff2=0, im=0, reg_i=8'h00.
